// File: rtl/npc_rf_pkg.sv
// Shared widths and writeback source indices for the register-file writeback path.
package npc_rf_pkg;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam logic SRC_EXU = 1'b0;
  localparam logic SRC_LSU = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; `last` remembers the most recent winner.
module rr_arb2
  import npc_rf_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic last;

  // Under contention the requester that did not win last time goes first.
  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = (last == SRC_EXU) ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          last <= SRC_LSU;
    else if (|gnt)     last <= gnt[SRC_LSU];
  end
endmodule

// File: rtl/regfile_wb_sched.sv
// Writeback arbitration onto the single register-file write port, plus the
// per-register busy scoreboard that stalls issue on RAW/WAW hazards.
module regfile_wb_sched #(
  parameter int XLEN   = npc_rf_pkg::XLEN,
  parameter int REG_AW = npc_rf_pkg::REG_AW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_valid,
  input  logic [REG_AW-1:0]      issue_rd,
  input  logic                   issue_rd_en,
  input  logic [REG_AW-1:0]      issue_rs1,
  input  logic                   issue_rs1_en,
  input  logic [REG_AW-1:0]      issue_rs2,
  input  logic                   issue_rs2_en,
  output logic                   issue_ready,
  input  logic                   exu_wb_valid,
  input  logic [REG_AW-1:0]      exu_wb_rd,
  input  logic [XLEN-1:0]        exu_wb_data,
  output logic                   exu_wb_ready,
  input  logic                   lsu_wb_valid,
  input  logic [REG_AW-1:0]      lsu_wb_rd,
  input  logic [XLEN-1:0]        lsu_wb_data,
  output logic                   lsu_wb_ready,
  output logic                   rf_wen,
  output logic [REG_AW-1:0]      rf_rd,
  output logic [XLEN-1:0]        rf_wdata,
  output logic [(1<<REG_AW)-1:0] sb_busy,
  output logic                   wb_err
);
  import npc_rf_pkg::*;

  localparam int NREGS = 1 << REG_AW;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  wb_req_t [1:0]    wb;
  wb_req_t          win;
  logic [1:0]       req, gnt;
  logic [NREGS-1:0] busy, busy_nxt;
  logic             fire, err_hit;

  assign wb[SRC_EXU] = '{rd: exu_wb_rd, data: exu_wb_data};
  assign wb[SRC_LSU] = '{rd: lsu_wb_rd, data: lsu_wb_data};
  assign req         = {lsu_wb_valid, exu_wb_valid};

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (req),
    .gnt (gnt)
  );

  assign exu_wb_ready = gnt[SRC_EXU];
  assign lsu_wb_ready = gnt[SRC_LSU];
  assign win          = wb[gnt[SRC_LSU]];

  assign issue_ready = !(issue_rs1_en && busy[issue_rs1]) &&
                       !(issue_rs2_en && busy[issue_rs2]) &&
                       !(issue_rd_en  && busy[issue_rd]);
  assign fire        = issue_valid && issue_ready;

  // A clear from the committing write and a set from a new issue can land on
  // the same register in one edge; the set is applied last so it wins.
  always_comb begin
    busy_nxt = busy;
    if (rf_wen) busy_nxt[rf_rd] = 1'b0;
    if (fire && issue_rd_en) busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  assign err_hit = (|gnt) && (win.rd != '0) && !busy[win.rd];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy     <= '0;
      rf_wen   <= 1'b0;
      rf_rd    <= '0;
      rf_wdata <= '0;
      wb_err   <= 1'b0;
    end else begin
      busy   <= busy_nxt;
      rf_wen <= |gnt;
      if (|gnt) begin
        rf_rd    <= win.rd;
        rf_wdata <= win.data;
      end
      if (err_hit) wb_err <= 1'b1;
    end
  end

  assign sb_busy = busy;
endmodule

// File: tb/tb_regfile_wb_sched.sv
// Randomized bench for regfile_wb_sched against a rule-level behavioural model,
// with directed scenarios pinning the model with literal expectations.
`timescale 1ns/100ps
module tb_regfile_wb_sched;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREGS  = 32;

  logic              clk, rst;
  logic              issue_valid, issue_rd_en, issue_rs1_en, issue_rs2_en, issue_ready;
  logic [REG_AW-1:0] issue_rd, issue_rs1, issue_rs2;
  logic              exu_wb_valid, exu_wb_ready, lsu_wb_valid, lsu_wb_ready;
  logic [REG_AW-1:0] exu_wb_rd, lsu_wb_rd, rf_rd;
  logic [XLEN-1:0]   exu_wb_data, lsu_wb_data, rf_wdata;
  logic              rf_wen, wb_err;
  logic [NREGS-1:0]  sb_busy;

  regfile_wb_sched #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rd_en(issue_rd_en),
    .issue_rs1(issue_rs1), .issue_rs1_en(issue_rs1_en),
    .issue_rs2(issue_rs2), .issue_rs2_en(issue_rs2_en), .issue_ready(issue_ready),
    .exu_wb_valid(exu_wb_valid), .exu_wb_rd(exu_wb_rd), .exu_wb_data(exu_wb_data),
    .exu_wb_ready(exu_wb_ready),
    .lsu_wb_valid(lsu_wb_valid), .lsu_wb_rd(lsu_wb_rd), .lsu_wb_data(lsu_wb_data),
    .lsu_wb_ready(lsu_wb_ready),
    .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .sb_busy(sb_busy), .wb_err(wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [NREGS-1:0]  m_busy;
  logic              m_last, m_rf_wen, m_err;
  logic [REG_AW-1:0] m_rf_rd;
  logic [XLEN-1:0]   m_rf_wdata;
  logic [1:0]        m_taken;

  function automatic logic m_ready();
    if (issue_rs1_en && m_busy[issue_rs1]) return 1'b0;
    if (issue_rs2_en && m_busy[issue_rs2]) return 1'b0;
    if (issue_rd_en  && m_busy[issue_rd])  return 1'b0;
    return 1'b1;
  endfunction

  // Returns {lsu_granted, exu_granted}.
  function automatic logic [1:0] m_gnt();
    if (exu_wb_valid && lsu_wb_valid) return (m_last == 1'b0) ? 2'b10 : 2'b01;
    if (exu_wb_valid) return 2'b01;
    if (lsu_wb_valid) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [NREGS-1:0] m_busy_next();
    logic [NREGS-1:0] b;
    b = m_busy;
    if (m_rf_wen) b[m_rf_rd] = 1'b0;
    if (issue_valid && m_ready() && issue_rd_en && issue_rd != 0) b[issue_rd] = 1'b1;
    return b;
  endfunction

  function automatic logic [REG_AW-1:0] m_wrd();
    return (m_gnt() == 2'b10) ? lsu_wb_rd : exu_wb_rd;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= '0; m_last <= 1'b1; m_rf_wen <= 1'b0; m_rf_rd <= '0;
      m_rf_wdata <= '0; m_err <= 1'b0; m_taken <= 2'b00;
    end else begin
      m_busy   <= m_busy_next();
      m_taken  <= m_gnt();
      m_rf_wen <= (m_gnt() != 2'b00);
      if (m_gnt() != 2'b00) begin
        m_last     <= (m_gnt() == 2'b10);
        m_rf_rd    <= m_wrd();
        m_rf_wdata <= (m_gnt() == 2'b10) ? lsu_wb_data : exu_wb_data;
        if (m_wrd() != 0 && !m_busy[m_wrd()]) m_err <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("issue_ready", 64'(issue_ready), 64'(m_ready()));
      chk("exu_wb_ready", 64'(exu_wb_ready), 64'(m_gnt() == 2'b01));
      chk("lsu_wb_ready", 64'(lsu_wb_ready), 64'(m_gnt() == 2'b10));
      chk("rf_wen", 64'(rf_wen), 64'(m_rf_wen));
      if (m_rf_wen) begin
        chk("rf_rd", 64'(rf_rd), 64'(m_rf_rd));
        chk("rf_wdata", 64'(rf_wdata), 64'(m_rf_wdata));
      end
      chk("sb_busy", 64'(sb_busy), 64'(m_busy));
      chk("wb_err", 64'(wb_err), 64'(m_err));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic clr_inputs();
    issue_valid = 0; issue_rd = 0; issue_rd_en = 0; issue_rs1 = 0; issue_rs1_en = 0;
    issue_rs2 = 0; issue_rs2_en = 0;
    exu_wb_valid = 0; exu_wb_rd = 0; exu_wb_data = 0;
    lsu_wb_valid = 0; lsu_wb_rd = 0; lsu_wb_data = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 0; clr_inputs(); #1;
    chk("rst_rf_wen", 64'(rf_wen), 64'd0);
    chk("rst_rf_rd", 64'(rf_rd), 64'd0);
    chk("rst_rf_wdata", 64'(rf_wdata), 64'd0);
    chk("rst_sb_busy", 64'(sb_busy), 64'd0);
    chk("rst_wb_err", 64'(wb_err), 64'd0);
    chk("rst_issue_ready", 64'(issue_ready), 64'd1);
    @(posedge clk); #1 rst = 1;
  endtask

  function automatic logic [REG_AW-1:0] pick_rd();
    if ($urandom_range(0, 1) == 1 && m_busy != 0) begin
      for (int t = 0; t < 64; t++) begin
        logic [REG_AW-1:0] r;
        r = REG_AW'($urandom_range(1, NREGS - 1));
        if (m_busy[r]) return r;
      end
    end
    return REG_AW'($urandom_range(0, NREGS - 1));
  endfunction

  initial begin
    rst = 0;
    clr_inputs();
    do_reset();

    // RAW stall and writeback latency
    issue_valid = 1; issue_rd = 5; issue_rd_en = 1; cyc();
    issue_valid = 0; issue_rd_en = 0; issue_rs1 = 5; issue_rs1_en = 1; #2;
    chk("raw_busy5", 64'(sb_busy[5]), 64'd1);
    chk("raw_stall", 64'(issue_ready), 64'd0);
    exu_wb_valid = 1; exu_wb_rd = 5; exu_wb_data = 32'hDEADBEEF; #2;
    chk("raw_exu_gnt", 64'(exu_wb_ready), 64'd1);
    cyc(); exu_wb_valid = 0; #2;
    chk("raw_rf_wen", 64'(rf_wen), 64'd1);
    chk("raw_rf_rd", 64'(rf_rd), 64'd5);
    chk("raw_rf_wdata", 64'(rf_wdata), 64'hDEADBEEF);
    chk("raw_still_stall", 64'(issue_ready), 64'd0);
    cyc(); #2;
    chk("raw_release", 64'(issue_ready), 64'd1);
    issue_rs1_en = 0;

    // Alternating grants under contention
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      issue_valid = 1; issue_rd = REG_AW'(k); issue_rd_en = 1; cyc();
    end
    issue_valid = 0; issue_rd_en = 0;
    exu_wb_valid = 1; exu_wb_rd = 1; exu_wb_data = 32'h101;
    lsu_wb_valid = 1; lsu_wb_rd = 2; lsu_wb_data = 32'h202; #2;
    chk("rr_g0_exu", 64'(exu_wb_ready), 64'd1);
    cyc(); exu_wb_rd = 3; exu_wb_data = 32'h303; #2;
    chk("rr_g1_lsu", 64'(lsu_wb_ready), 64'd1);
    chk("rr_w0", 64'({rf_wen, rf_rd}), 64'({1'b1, 5'd1}));
    cyc(); lsu_wb_rd = 4; lsu_wb_data = 32'h404; #2;
    chk("rr_g2_exu", 64'(exu_wb_ready), 64'd1);
    chk("rr_w1", 64'({rf_wen, rf_rd}), 64'({1'b1, 5'd2}));
    cyc(); exu_wb_valid = 0; #2;
    chk("rr_g3_lsu", 64'(lsu_wb_ready), 64'd1);
    chk("rr_w2", 64'({rf_wen, rf_rd}), 64'({1'b1, 5'd3}));
    cyc(); lsu_wb_valid = 0; #2;
    chk("rr_w3", 64'({rf_wen, rf_rd, rf_wdata}), 64'({1'b1, 5'd4, 32'h404}));
    cyc(); #2;
    chk("rr_idle", 64'(rf_wen), 64'd0);

    // Writeback to x0
    exu_wb_valid = 1; exu_wb_rd = 0; exu_wb_data = 32'h55; cyc(); exu_wb_valid = 0; #2;
    chk("x0_wen", 64'({rf_wen, rf_rd}), 64'({1'b1, 5'd0}));
    chk("x0_busy", 64'(sb_busy), 64'd0);
    chk("x0_err", 64'(wb_err), 64'd0);

    // Stray writeback to non-busy x9
    lsu_wb_valid = 1; lsu_wb_rd = 9; lsu_wb_data = 32'h99; cyc(); lsu_wb_valid = 0; #2;
    chk("err_write", 64'({rf_wen, rf_rd}), 64'({1'b1, 5'd9}));
    chk("err_set", 64'(wb_err), 64'd1);
    repeat (3) cyc(); #2;
    chk("err_sticky", 64'(wb_err), 64'd1);

    // WAW stall, then set-wins on the edge x7 commits
    issue_valid = 1; issue_rd = 7; issue_rd_en = 1; cyc(); #2;
    chk("waw_busy7", 64'(sb_busy[7]), 64'd1);
    chk("waw_stall", 64'(issue_ready), 64'd0);
    exu_wb_valid = 1; exu_wb_rd = 7; exu_wb_data = 32'h77; cyc();
    exu_wb_valid = 0; issue_valid = 0; cyc(); #2;
    chk("waw_clear", 64'({sb_busy[7], issue_ready}), 64'b01);
    exu_wb_valid = 1; exu_wb_rd = 7; cyc();
    exu_wb_valid = 0; issue_valid = 1; #2;
    chk("sw_commit", 64'({rf_wen, rf_rd, issue_ready}), 64'({1'b1, 5'd7, 1'b1}));
    cyc(); issue_valid = 0; issue_rd_en = 0; #2;
    chk("set_wins", 64'(sb_busy[7]), 64'd1);

    // Asynchronous reset mid-handshake
    do_reset();
    issue_valid = 1; issue_rd_en = 1; issue_rd = 3; cyc();
    issue_rd = 8; cyc();
    issue_valid = 0; issue_rd_en = 0;
    lsu_wb_valid = 1; lsu_wb_rd = 3; lsu_wb_data = 32'h333; #1;
    chk("ar_lsu_gnt", 64'(lsu_wb_ready), 64'd1);
    chk("ar_busy", 64'(sb_busy), 64'h108);
    #1 rst = 0; #1;
    chk("ar_wen", 64'(rf_wen), 64'd0);
    chk("ar_rd_data", 64'({rf_rd, rf_wdata}), 64'd0);
    chk("ar_busy0", 64'(sb_busy), 64'd0);
    chk("ar_err", 64'(wb_err), 64'd0);
    chk("ar_ready", 64'(issue_ready), 64'd1);
    @(posedge clk); #1 rst = 1; lsu_wb_valid = 0; #2;
    chk("ar_after_wen", 64'(rf_wen), 64'd0);
    chk("ar_after_busy", 64'(sb_busy), 64'd0);

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if (!(exu_wb_valid && !m_taken[0])) begin
        exu_wb_valid = ($urandom_range(0, 2) != 0);
        exu_wb_rd    = pick_rd();
        exu_wb_data  = $urandom;
      end
      if (!(lsu_wb_valid && !m_taken[1])) begin
        lsu_wb_valid = ($urandom_range(0, 2) != 0);
        lsu_wb_rd    = pick_rd();
        lsu_wb_data  = $urandom;
      end
      issue_valid  = $urandom_range(0, 1);
      issue_rd     = REG_AW'($urandom_range(0, 15));
      issue_rs1    = REG_AW'($urandom_range(0, 15));
      issue_rs2    = REG_AW'($urandom_range(0, 15));
      issue_rd_en  = $urandom_range(0, 1);
      issue_rs1_en = $urandom_range(0, 1);
      issue_rs2_en = $urandom_range(0, 1);
      cyc();
    end
    clr_inputs();
    repeat (2) cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
